// File: rtl/spike_window_counter.sv
// spike_window_counter: counts spikes over back-to-back windows of WINDOW clk cycles and hands
// each total to a valid/ready consumer. Define SPIKE_RUN_LEN_EN to add the longest-run output out_run.
module spike_window_counter #(
  parameter int WINDOW = 64,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic             en,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
`ifdef SPIKE_RUN_LEN_EN
  output logic [CNT_W-1:0] out_run,
`endif
  output logic             busy
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_COUNT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  logic             spk_tog_r;
  logic             spk_prev_r;
  logic             spk_evt_s;
  logic [0:0]       state_r;
  logic [CNT_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] spk_cnt_r;
  logic [CNT_W-1:0] spk_sum_s;
  logic             win_end_s;
  logic             slot_free_s;
  logic             xfer_s;
  logic [CNT_W-1:0] out_count_r;
  logic             out_valid_r;
  logic             overrun_r;

  // The pulse is already low at every clk edge, so its rising edge flips a toggle instead.
  always_ff @(posedge spike_in) begin
    spk_tog_r <= ~spk_tog_r;
  end

  // Per-edge event, running sum including this edge's event, and output-slot decisions.
  always_comb begin
    spk_evt_s   = spk_tog_r ^ spk_prev_r;
    spk_sum_s   = spk_cnt_r + (spk_evt_s ? CNT_ONE : CNT_ZERO);
    win_end_s   = 1'b0;
    if ((state_r == ST_COUNT) && en && (win_cnt_r == WIN_LAST)) begin
      win_end_s = 1'b1;
    end else begin
      win_end_s = 1'b0;
    end
    xfer_s      = out_valid_r & out_ready;
    slot_free_s = ~out_valid_r | out_ready;
  end

  // Window FSM; loading spk_prev on reset swallows any toggle pending at that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spk_prev_r <= spk_tog_r;
      state_r    <= ST_IDLE;
      win_cnt_r  <= CNT_ZERO;
      spk_cnt_r  <= CNT_ZERO;
    end else begin
      spk_prev_r <= spk_tog_r;
      case (state_r)
        ST_IDLE: begin
          win_cnt_r <= CNT_ZERO;
          spk_cnt_r <= CNT_ZERO;
          if (en) begin
            state_r <= ST_COUNT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            state_r   <= ST_IDLE;
            win_cnt_r <= CNT_ZERO;
            spk_cnt_r <= CNT_ZERO;
          end else if (win_end_s) begin
            state_r   <= ST_COUNT;
            win_cnt_r <= CNT_ZERO;
            spk_cnt_r <= CNT_ZERO;
          end else begin
            state_r   <= ST_COUNT;
            win_cnt_r <= win_cnt_r + CNT_ONE;
            spk_cnt_r <= spk_sum_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          win_cnt_r <= CNT_ZERO;
          spk_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Single-entry output slot: a full, unaccepted slot drops the new result and flags overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_count_r <= CNT_ZERO;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (win_end_s && slot_free_s) begin
      out_count_r <= spk_sum_s;
      out_valid_r <= 1'b1;
    end else if (win_end_s) begin
      overrun_r   <= 1'b1;
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef SPIKE_RUN_LEN_EN
  logic [CNT_W-1:0] cur_run_r;
  logic [CNT_W-1:0] max_run_r;
  logic [CNT_W-1:0] run_next_s;
  logic [CNT_W-1:0] max_next_s;
  logic [CNT_W-1:0] out_run_r;

  function automatic logic [CNT_W-1:0] max_of(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Run length including this edge's event, and the window maximum so far.
  always_comb begin
    run_next_s = CNT_ZERO;
    if (spk_evt_s) begin
      run_next_s = cur_run_r + CNT_ONE;
    end else begin
      run_next_s = CNT_ZERO;
    end
    max_next_s = max_of(max_run_r, run_next_s);
  end

  // Run trackers restart at every window boundary, abort and idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_run_r <= CNT_ZERO;
      max_run_r <= CNT_ZERO;
    end else if ((state_r == ST_COUNT) && en && !win_end_s) begin
      cur_run_r <= run_next_s;
      max_run_r <= max_next_s;
    end else begin
      cur_run_r <= CNT_ZERO;
      max_run_r <= CNT_ZERO;
    end
  end

  // out_run loads and holds in lockstep with out_count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_run_r <= CNT_ZERO;
    end else if (win_end_s && slot_free_s) begin
      out_run_r <= max_next_s;
    end else begin
      out_run_r <= out_run_r;
    end
  end

  assign out_run = out_run_r;
`endif

  assign out_count = out_count_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;
  assign busy      = (state_r == ST_COUNT);

endmodule

// File: tb/tb_spike_window_counter.sv
// Bench for spike_window_counter (WINDOW=8): table of per-window spike masks with a result
// scoreboard, plus directed abort, hold/overrun and mid-window reset sequences.
module tb_spike_window_counter;

  localparam int WINDOW = 8;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             spike_in;
  logic             en;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             overrun;
  logic             busy;
`ifdef SPIKE_RUN_LEN_EN
  logic [CNT_W-1:0] out_run;
`endif

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run;
  } exp_t;

  typedef struct {
    logic [7:0]       mask;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spike_window_counter #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .en        (en),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
`ifdef SPIKE_RUN_LEN_EN
    .out_run   (out_run),
`endif
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clk period: drive inputs just after the edge, pulse spike until the falling edge,
  // then return #1 after the next rising edge. A held result is compared against the
  // scoreboard every cycle and popped when the coming edge will accept it.
  task automatic cyc(input logic spk, input logic e, input logic r, input logic rs);
    en        = e;
    out_ready = r;
    rst_n     = rs;
    spike_in  = spk;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: out_valid=1 count=%0d with no expected result", out_count);
      end else begin
        check("out_count", out_count, sb_q[0].cnt);
`ifdef SPIKE_RUN_LEN_EN
        check("out_run", out_run, sb_q[0].run);
`endif
        if (!rs) sb_q.delete();
        else if (r) void'(sb_q.pop_front());
      end
    end
    @(negedge clk);
    spike_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    spike_in  = 1'b0;

    vecs[0] = '{mask: 8'h00, cnt: 4'd0, run: 4'd0};
    vecs[1] = '{mask: 8'hFF, cnt: 4'd8, run: 4'd8};
    vecs[2] = '{mask: 8'h55, cnt: 4'd4, run: 4'd1};
    vecs[3] = '{mask: 8'hAA, cnt: 4'd4, run: 4'd1};
    vecs[4] = '{mask: 8'h80, cnt: 4'd1, run: 4'd1};
    vecs[5] = '{mask: 8'h01, cnt: 4'd1, run: 4'd1};
    vecs[6] = '{mask: 8'hF0, cnt: 4'd4, run: 4'd4};
    vecs[7] = '{mask: 8'h0F, cnt: 4'd4, run: 4'd4};
    vecs[8] = '{mask: 8'hF7, cnt: 4'd7, run: 4'd4};

    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_out_count", out_count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_busy", busy, 0);

    // Back-to-back windows from the table; result must appear exactly at each window end.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("start_busy", busy, 1);
    for (int v = 0; v < 9; v++) begin
      sb_q.push_back('{cnt: vecs[v].cnt, run: vecs[v].run});
      for (int i = 0; i < WINDOW; i++) begin
        cyc(vecs[v].mask[i], 1'b1, 1'b1, 1'b1);
        check("tbl_valid_phase", out_valid, (i == WINDOW - 1));
        check("tbl_busy", busy, 1);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("stop_busy", busy, 0);
    check("stop_valid", out_valid, 0);

    // Abort after 5 window cycles holding 3 spikes; restart must count from zero.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    repeat (WINDOW) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_no_out", out_valid, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    sb_q.push_back('{cnt: 4'd0, run: 4'd0});
    for (int i = 0; i < WINDOW; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("restart_valid", out_valid, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("restart_done", out_valid, 0);

    // Consumer stalled for 20 cycles: first result held, second dropped with overrun.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    sb_q.push_back('{cnt: 4'd2, run: 4'd2});
    for (int i = 0; i < WINDOW; i++) cyc((i < 2), 1'b1, 1'b0, 1'b1);
    check("hold_first_valid", out_valid, 1);
    check("hold_no_overrun", overrun, 0);
    for (int i = 0; i < WINDOW; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("hold_overrun", overrun, 1);
    check("hold_stable", out_count, 2);
    check("hold_busy", busy, 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_still_valid", out_valid, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("hold_xfer_valid", out_valid, 0);
    check("hold_xfer_count", out_count, 2);
    check("overrun_sticky", overrun, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("overrun_sticky2", overrun, 1);

    // Reset mid-window with a spike landing just before the reset edge.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_busy", busy, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    sb_q.push_back('{cnt: 4'd0, run: 4'd0});
    for (int i = 0; i < WINDOW; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("post_rst_valid", out_valid, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
